// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   XLEN / NUM_LANES : data width and number of byte lanes
//   F3_*             : RV32I load/store funct3 encodings
//   state_e          : responder FSM state encoding
package dmem_responder_pkg;

   localparam int XLEN      = 32;
   localparam int NUM_LANES = XLEN / 8;

   localparam logic [2:0] F3_B  = 3'd0;   // LB / SB
   localparam logic [2:0] F3_H  = 3'd1;   // LH / SH
   localparam logic [2:0] F3_W  = 3'd2;   // LW / SW
   localparam logic [2:0] F3_BU = 3'd4;   // LBU
   localparam logic [2:0] F3_HU = 3'd5;   // LHU

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_responder_align.sv
// Combinational lane logic for one access.
//   write_i   : 1 = store, 0 = load
//   funct3_i  : RV32I width/sign code
//   addr_lo_i : byte offset within the word
//   wdata_i   : right-aligned store data
//   rword_i   : current RAM word at the access index
//   be_o      : byte enables for the store
//   wword_o   : store data replicated onto every lane it may occupy
//   rdata_o   : extracted and extended load data
//   fmt_err_o : misaligned access or illegal funct3
module dmem_responder_align
   import dmem_responder_pkg::*;
(
   input  logic                 write_i,
   input  logic [2:0]           funct3_i,
   input  logic [1:0]           addr_lo_i,
   input  logic [XLEN-1:0]      wdata_i,
   input  logic [XLEN-1:0]      rword_i,
   output logic [NUM_LANES-1:0] be_o,
   output logic [XLEN-1:0]      wword_o,
   output logic [XLEN-1:0]      rdata_o,
   output logic                 fmt_err_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
   assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

   always_comb begin
      be_o      = '0;
      wword_o   = wdata_i;
      rdata_o   = '0;
      fmt_err_o = 1'b0;
      case (funct3_i)
         F3_B, F3_BU: begin
            be_o    = 4'b0001 << addr_lo_i;
            wword_o = {4{wdata_i[7:0]}};
            rdata_o = (funct3_i == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                         : {24'd0, byte_sel};
         end
         F3_H, F3_HU: begin
            fmt_err_o = addr_lo_i[0];
            be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wword_o   = {2{wdata_i[15:0]}};
            rdata_o   = (funct3_i == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                           : {16'd0, half_sel};
         end
         F3_W: begin
            fmt_err_o = (addr_lo_i != 2'b00);
            be_o      = '1;
            rdata_o   = rword_i;
         end
         default: fmt_err_o = 1'b1;
      endcase
      // Unsigned variants exist only for loads.
      if (write_i && funct3_i[2])
         fmt_err_o = 1'b1;
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store over req valid/ready,
// executes it after WAIT_STATES cycles and holds a registered response
// until the core takes it.
//   clk_i, rst_ni                     : clock, async active-low reset
//   req_valid_i / req_ready_o         : request handshake
//   req_write_i, req_funct3_i,
//   req_addr_i, req_wdata_i           : request fields
//   rsp_valid_o / rsp_ready_i         : response handshake
//   rsp_rdata_o, rsp_error_o          : response fields
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_write_i,
   input  logic [2:0]      req_funct3_i,
   input  logic [31:0]     req_addr_i,
   input  logic [XLEN-1:0] req_wdata_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_rdata_o,
   output logic            rsp_error_o
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_e          state_q;
   logic [3:0]      cnt_q;
   logic            wr_q;
   logic [2:0]      f3_q;
   logic [31:0]     addr_q;
   logic [XLEN-1:0] wdata_q;
   logic            req_ready_q, rsp_valid_q, rsp_error_q;
   logic [XLEN-1:0] rsp_rdata_q;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   // With zero wait states the access executes on the accepting edge, so
   // the fields come straight from the request port instead of the latch.
   logic            use_in, a_wr;
   logic [2:0]      a_f3;
   logic [31:0]     a_addr;
   logic [XLEN-1:0] a_wdata;
   assign use_in  = (state_q == ST_IDLE);
   assign a_wr    = use_in ? req_write_i  : wr_q;
   assign a_f3    = use_in ? req_funct3_i : f3_q;
   assign a_addr  = use_in ? req_addr_i   : addr_q;
   assign a_wdata = use_in ? req_wdata_i  : wdata_q;

   logic          accept, exec, range_err, acc_err, fmt_err;
   logic [AW-1:0] widx;
   logic [NUM_LANES-1:0] be;
   logic [XLEN-1:0] rword, wword, ld_data;

   assign accept    = req_valid_i && req_ready_q;
   assign exec      = (state_q == ST_IDLE && accept && WAIT_STATES == 0) ||
                      (state_q == ST_WAIT && cnt_q == 4'd0);
   assign range_err = ({2'b00, a_addr[31:2]} >= DEPTH_WORDS);
   assign widx      = a_addr[AW+1:2];
   assign rword     = mem[widx];
   assign acc_err   = fmt_err || range_err;

   dmem_responder_align u_align (
      .write_i   (a_wr),
      .funct3_i  (a_f3),
      .addr_lo_i (a_addr[1:0]),
      .wdata_i   (a_wdata),
      .rword_i   (rword),
      .be_o      (be),
      .wword_o   (wword),
      .rdata_o   (ld_data),
      .fmt_err_o (fmt_err)
   );

   // RAM is not reset; the store commits on the edge that enters RESP.
   always_ff @(posedge clk_i) begin
      if (exec && a_wr && !acc_err) begin
         for (int l = 0; l < NUM_LANES; l++)
            if (be[l]) mem[widx][8*l +: 8] <= wword[8*l +: 8];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         f3_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         if (exec) begin
            state_q     <= ST_RESP;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (acc_err || a_wr) ? '0 : ld_data;
            rsp_error_q <= acc_err;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  wr_q        <= req_write_i;
                  f3_q        <= req_funct3_i;
                  addr_q      <= req_addr_i;
                  wdata_q     <= req_wdata_i;
                  req_ready_q <= 1'b0;
                  if (WAIT_STATES != 0) begin
                     state_q <= ST_WAIT;
                     cnt_q   <= 4'(WAIT_STATES - 1);
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 (WAIT_STATES=1) and instance 1
// (WAIT_STATES=3), checked against a byte-array reference model.
module tb_dmem_responder;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n     [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_write [2];
   logic [2:0]  req_f3    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_error [2];

   int ws_of [2] = '{1, 3};
   int n_chk = 0;
   int n_err = 0;

   logic [7:0] rmem [2][4*DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut0 (
      .clk_i(clk), .rst_ni(rst_n[0]),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
      .req_write_i(req_write[0]), .req_funct3_i(req_f3[0]),
      .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
      .rsp_rdata_o(rsp_rdata[0]), .rsp_error_o(rsp_error[0]));

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut1 (
      .clk_i(clk), .rst_ni(rst_n[1]),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
      .req_write_i(req_write[1]), .req_funct3_i(req_f3[1]),
      .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
      .rsp_rdata_o(rsp_rdata[1]), .rsp_error_o(rsp_error[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: access rules applied to a flat byte array.
   task automatic model(input int i, input bit w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er);
      int nb;
      logic [31:0] v;
      er = 1'b0; rd = 32'd0; v = 32'd0; nb = 1;
      case (f3[1:0])
         2'd0:    nb = 1;
         2'd1:    nb = 2;
         2'd2:    nb = 4;
         default: er = 1'b1;
      endcase
      if (w && f3 > 3'd2) er = 1'b1;
      if (!w && (f3 == 3'd3 || f3 >= 3'd6)) er = 1'b1;
      if ((a % nb) != 0) er = 1'b1;
      if ((a / 4) >= DEPTH) er = 1'b1;
      if (!er) begin
         if (w) begin
            for (int k = 0; k < nb; k++) rmem[i][a + k] = wd[8*k +: 8];
         end else begin
            for (int k = 0; k < nb; k++) v[8*k +: 8] = rmem[i][a + k];
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            rd = v;
         end
      end
   endtask

   // One full transaction; checks latency, response against the model,
   // stability while rsp_ready is held low, and the return to idle.
   task automatic do_op(input int i, input bit w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er);
      logic [31:0] erd;
      bit eer;
      int edges;
      bit busy_ok;
      model(i, w, f3, a, wd, erd, eer);
      @(negedge clk);
      for (int k = 0; k < 50 && !req_ready[i]; k++) @(negedge clk);
      check("ready_idle", 32'(req_ready[i]), 32'd1);
      req_write[i] = w; req_f3[i] = f3; req_addr[i] = a; req_wdata[i] = wd;
      req_valid[i] = 1'b1;
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
      req_addr[i]  = $urandom;
      req_wdata[i] = $urandom;
      edges = 1;
      busy_ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (req_ready[i]) busy_ok = 1'b0;
         if (rsp_valid[i]) break;
         @(posedge clk);
         edges++;
      end
      check("latency", 32'(edges), 32'(ws_of[i] + 1));
      rd = rsp_rdata[i];
      er = rsp_error[i];
      check("rdata", rd, erd);
      check("error", 32'(er), 32'(eer));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (req_ready[i] || !rsp_valid[i] || rsp_rdata[i] !== rd || rsp_error[i] !== er)
            busy_ok = 1'b0;
      end
      check("busy_stable", 32'(busy_ok), 32'd1);
      rsp_ready[i] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[i] = 1'b0;
      @(negedge clk);
      check("valid_drop", 32'(rsp_valid[i]), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0;
         req_f3[i] = 3'd0; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
         rsp_ready[i] = 1'b0;
      end

      // Reset release
      #22;
      check("rst_ready", 32'(req_ready[0]), 32'd0);
      check("rst_valid", 32'(rsp_valid[0]), 32'd0);
      check("rst_rdata", rsp_rdata[0], 32'd0);
      check("rst_error", 32'(rsp_error[0]), 32'd0);
      @(negedge clk);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      #1;
      check("rel_ready_low", 32'(req_ready[0]), 32'd0);
      @(posedge clk);
      #1;
      check("rel_ready_high", 32'(req_ready[0]), 32'd1);
      check("rel_valid", 32'(rsp_valid[0]), 32'd0);

      // Bring the whole RAM to a known state
      for (int wi = 0; wi < DEPTH; wi++) do_op(0, 1'b1, 3'd2, 32'(wi * 4), 32'd0, 0, rd, er);

      // Directed cases
      do_op(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
      do_op(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
      check("lw_dead", rd, 32'hDEADBEEF);
      check("lw_dead_err", 32'(er), 32'd0);
      do_op(0, 1'b1, 3'd2, 32'h10, 32'h0, 0, rd, er);
      do_op(0, 1'b1, 3'd0, 32'h11, 32'h80, 0, rd, er);
      do_op(0, 1'b0, 3'd0, 32'h11, 32'd0, 0, rd, er);
      check("lb_sext", rd, 32'hFFFFFF80);
      do_op(0, 1'b0, 3'd4, 32'h11, 32'd0, 0, rd, er);
      check("lbu_zext", rd, 32'h00000080);
      do_op(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
      check("lw_lane1", rd, 32'h00008000);
      do_op(0, 1'b1, 3'd1, 32'h13, 32'h1234, 0, rd, er);
      check("sh_mis_err", 32'(er), 32'd1);
      do_op(0, 1'b0, 3'd2, 32'h12, 32'd0, 0, rd, er);
      check("lw_mis_err", 32'(er), 32'd1);
      check("lw_mis_data", rd, 32'd0);
      do_op(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
      check("lw_unchanged", rd, 32'h00008000);
      do_op(0, 1'b0, 3'd2, 32'(DEPTH * 4), 32'd0, 5, rd, er);
      check("lw_range_err", 32'(er), 32'd1);
      do_op(0, 1'b0, 3'd3, 32'h10, 32'd0, 5, rd, er);
      check("ld_f3_3_err", 32'(er), 32'd1);

      // Randomised traffic
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH - 1));
         do_op(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
               $urandom_range(0, 2), rd, er);
      end

      // Reset while a store sits in WAIT on the 3-wait-state instance
      do_op(1, 1'b1, 3'd2, 32'h20, 32'hA5A5_1234, 0, rd, er);
      @(negedge clk);
      req_write[1] = 1'b1; req_f3[1] = 3'd2; req_addr[1] = 32'h20;
      req_wdata[1] = 32'h0BAD_F00D; req_valid[1] = 1'b1;
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      @(posedge clk);
      #1;
      rst_n[1] = 1'b0;
      #1;
      check("mid_rst_ready", 32'(req_ready[1]), 32'd0);
      check("mid_rst_valid", 32'(rsp_valid[1]), 32'd0);
      check("mid_rst_rdata", rsp_rdata[1], 32'd0);
      repeat (2) @(negedge clk);
      rst_n[1] = 1'b1;
      do_op(1, 1'b0, 3'd2, 32'h20, 32'd0, 0, rd, er);
      check("dropped_store", rd, 32'hA5A5_1234);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
